// File: rtl/uart_tx_arbiter_pkg.sv
// Purpose: shared defaults, FSM state type and helpers for the UART TX arbiter.
// Ports: none (package).
package uart_tx_arbiter_pkg;

  localparam int unsigned UART_ARB_NUM_REQ = 2;
  localparam int unsigned UART_ARB_TIMEOUT = 50000;
  localparam int unsigned UART_ARB_TO_BITS = 16;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_GUARD   = 2'd2,
    S_WAIT_TX = 2'd3
  } arb_state_e;

  // Index width for n requesters; never below one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Purpose: combinational round-robin pick; first set request searching from iPtr upward, wrapping.
// Ports:
//   iReq    in  N   request vector
//   iPtr    in  IW  highest-priority index
//   oOneHot out N   one-hot of the winner, 0 when no request
//   oIdx    out IW  index of the winner
//   oAny    out 1   any request set
module uart_tx_arbiter_rr_pick
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = idx_width(N)
) (
  input  logic [N-1:0]  iReq,
  input  logic [IW-1:0] iPtr,
  output logic [N-1:0]  oOneHot,
  output logic [IW-1:0] oIdx,
  output logic          oAny
);

  int w_best;
  int w_dist;

  // Winner is the set request with the smallest circular distance from iPtr.
  always_comb begin
    w_best  = int'(N);
    w_dist  = 0;
    oIdx    = '0;
    oAny    = 1'b0;
    oOneHot = '0;
    for (int r = 0; r < int'(N); r++) begin
      w_dist = (r >= int'(iPtr)) ? (r - int'(iPtr)) : (r + int'(N) - int'(iPtr));
      if (iReq[r] && (w_dist < w_best)) begin
        w_best = w_dist;
        oIdx   = IW'(r);
        oAny   = 1'b1;
      end
    end
    for (int r = 0; r < int'(N); r++) begin
      oOneHot[r] = oAny && (oIdx == IW'(r));
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Purpose: shares one UART serialiser between NUM_REQ byte sources with round-robin grant
//          and a per-requester message lock released by a Last byte or an idle timeout.
// Ports:
//   iClk, iRst          clock, synchronous active-high reset
//   iReqValid/Data/Last per-requester byte stream (requester r at iReqData[8r+7:8r])
//   oReqReady           accept strobe to the owner, byte consumed at this edge
//   oGrant              one-hot current owner, 0 when idle
//   oTxData, oTxStart   byte and start strobe to the serialiser
//   iTxReady            serialiser idle
//   oBusy               arbiter not idle
//   oTimeout            one-cycle pulse on forced lock release
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ      = UART_ARB_NUM_REQ,
  parameter int unsigned LOCK_TIMEOUT = UART_ARB_TIMEOUT,
  parameter int unsigned TO_BITS      = UART_ARB_TO_BITS
) (
  input  logic                 iClk,
  input  logic                 iRst,
  input  logic [NUM_REQ-1:0]   iReqValid,
  input  logic [8*NUM_REQ-1:0] iReqData,
  input  logic [NUM_REQ-1:0]   iReqLast,
  output logic [NUM_REQ-1:0]   oReqReady,
  output logic [NUM_REQ-1:0]   oGrant,
  output logic [7:0]           oTxData,
  output logic                 oTxStart,
  input  logic                 iTxReady,
  output logic                 oBusy,
  output logic                 oTimeout
);

  localparam int unsigned        IDX_W   = idx_width(NUM_REQ);
  localparam logic [TO_BITS-1:0] TO_LAST = TO_BITS'(LOCK_TIMEOUT - 1);

  arb_state_e         r_state;
  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   r_idx;
  logic [NUM_REQ-1:0] r_grant;
  logic [7:0]         r_tx_data;
  logic               r_tx_start;
  logic               r_last;
  logic               r_timeout;
  logic [TO_BITS-1:0] r_to_cnt;

  logic [NUM_REQ-1:0] w_pick_onehot;
  logic [IDX_W-1:0]   w_pick_idx;
  logic               w_pick_any;
  logic               w_own_valid;
  logic               w_own_last;
  logic [7:0]         w_own_data;
  logic [IDX_W-1:0]   w_next_ptr;
  logic               w_accept;

  uart_tx_arbiter_rr_pick #(
    .N  (NUM_REQ),
    .IW (IDX_W)
  ) u_pick (
    .iReq    (iReqValid),
    .iPtr    (r_ptr),
    .oOneHot (w_pick_onehot),
    .oIdx    (w_pick_idx),
    .oAny    (w_pick_any)
  );

  // Owner's request signals, selected by the registered owner index.
  always_comb begin
    w_own_valid = 1'b0;
    w_own_last  = 1'b0;
    w_own_data  = 8'h00;
    for (int r = 0; r < int'(NUM_REQ); r++) begin
      if (r_idx == IDX_W'(r)) begin
        w_own_valid = iReqValid[r];
        w_own_last  = iReqLast[r];
        w_own_data  = iReqData[8*r +: 8];
      end
    end
  end

  assign w_next_ptr = (r_idx == IDX_W'(NUM_REQ - 1)) ? '0 : (r_idx + IDX_W'(1));
  assign w_accept   = (r_state == S_ISSUE) && w_own_valid && iTxReady;

  assign oReqReady = w_accept ? r_grant : '0;
  assign oGrant    = r_grant;
  assign oTxData   = r_tx_data;
  assign oTxStart  = r_tx_start;
  assign oBusy     = (r_state != S_IDLE);
  assign oTimeout  = r_timeout;

  // Arbiter FSM with registered outputs.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_idx      <= '0;
      r_grant    <= '0;
      r_tx_data  <= 8'h00;
      r_tx_start <= 1'b0;
      r_last     <= 1'b0;
      r_timeout  <= 1'b0;
      r_to_cnt   <= '0;
    end else begin
      r_tx_start <= 1'b0;
      r_timeout  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_pick_any) begin
            r_grant  <= w_pick_onehot;
            r_idx    <= w_pick_idx;
            r_to_cnt <= '0;
            r_state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (w_accept) begin
            r_tx_data  <= w_own_data;
            r_last     <= w_own_last;
            r_tx_start <= 1'b1;
            r_to_cnt   <= '0;
            r_state    <= S_GUARD;
          end else if (!w_own_valid) begin
            // Locked owner went quiet between bytes; count toward forced release.
            if (r_to_cnt == TO_LAST) begin
              r_timeout <= 1'b1;
              r_grant   <= '0;
              r_ptr     <= w_next_ptr;
              r_to_cnt  <= '0;
              r_state   <= S_IDLE;
            end else begin
              r_to_cnt <= r_to_cnt + TO_BITS'(1);
            end
          end
        end
        // One cycle for the serialiser to drop ready after the start strobe.
        S_GUARD: r_state <= S_WAIT_TX;
        S_WAIT_TX: begin
          if (iTxReady) begin
            if (r_last) begin
              r_grant <= '0;
              r_ptr   <= w_next_ptr;
              r_state <= S_IDLE;
            end else begin
              r_state <= S_ISSUE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

  localparam int unsigned LT       = 8;
  localparam int          BUSY_CYC = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_last, req_ready, grant;
  logic [15:0] req_data;
  logic [7:0]  tx_data;
  logic        tx_start, tx_ready, busy, timeout;
  logic        bp_hold;
  int          stub_cnt = 0;

  int tests, fails;
  logic [7:0] qd0[$], qd1[$];
  bit         ql0[$], ql1[$];
  logic [7:0] cap_d[$], exp_d[$];
  int         cap_s[$], exp_s[$];

  logic [1:0] s_ready, s_grant;
  logic [7:0] s_data;
  logic       s_start, s_busy, s_timeout, prev_ready;
  int         cyc, n_timeout, t_timeout, t_start, bad_start;

  uart_tx_arbiter #(.NUM_REQ(2), .LOCK_TIMEOUT(LT), .TO_BITS(4)) dut (
    .iClk(clk), .iRst(rst), .iReqValid(req_valid), .iReqData(req_data), .iReqLast(req_last),
    .oReqReady(req_ready), .oGrant(grant), .oTxData(tx_data), .oTxStart(tx_start),
    .iTxReady(tx_ready), .oBusy(busy), .oTimeout(timeout)
  );

  always #5 clk = ~clk;

  // Serialiser stub: busy for BUSY_CYC cycles starting the cycle after a start strobe.
  assign tx_ready = (stub_cnt == 0) && !bp_hold;
  always @(posedge clk) begin
    if (tx_start) stub_cnt <= BUSY_CYC;
    else if (stub_cnt != 0) stub_cnt <= stub_cnt - 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic drive();
    req_valid[0] = (qd0.size() > 0);
    req_data[7:0] = req_valid[0] ? qd0[0] : 8'h00;
    req_last[0]   = req_valid[0] ? ql0[0] : 1'b0;
    req_valid[1] = (qd1.size() > 0);
    req_data[15:8] = req_valid[1] ? qd1[0] : 8'h00;
    req_last[1]    = req_valid[1] ? ql1[0] : 1'b0;
  endtask

  task automatic push(input int r, input logic [7:0] d, input bit l);
    if (r == 0) begin qd0.push_back(d); ql0.push_back(l); end
    else begin qd1.push_back(d); ql1.push_back(l); end
    drive();
  endtask

  // One clock: sample mid-cycle, then retire accepted bytes just after the edge.
  task automatic step();
    @(negedge clk);
    s_ready = req_ready; s_grant = grant; s_data = tx_data;
    s_start = tx_start; s_busy = busy; s_timeout = timeout;
    check("grant_onehot0", 32'($onehot0(s_grant)), 1);
    check("ready_owner_only", 32'(s_ready & ~s_grant), 0);
    if (s_start) begin
      cap_d.push_back(s_data);
      cap_s.push_back(s_grant[1] ? 1 : 0);
      if (cap_d.size() == 1) t_start = cyc;
      if (!prev_ready) bad_start++;
    end
    if (s_timeout) begin n_timeout++; t_timeout = cyc; end
    prev_ready = tx_ready;
    cyc++;
    @(posedge clk); #1;
    if (s_ready[0]) begin void'(qd0.pop_front()); void'(ql0.pop_front()); end
    if (s_ready[1]) begin void'(qd1.pop_front()); void'(ql1.pop_front()); end
    drive();
  endtask

  task automatic do_reset();
    rst = 1'b1; step(); step(); rst = 1'b0;
    cap_d.delete(); cap_s.delete();
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((qd0.size() != 0 || qd1.size() != 0 || busy || !tx_ready) && n < 3000) begin
      step(); n++;
    end
    check($sformatf("%s_done", tag), 32'(n < 3000), 1);
  endtask

  // Reference: with every requester backlogged, whole messages alternate between
  // requesters that still have data, starting from the given priority.
  function automatic void build_exp(input int start);
    logic [7:0] c0[$], c1[$];
    bit l0[$], l1[$];
    int turn;
    bit last;
    c0 = qd0; c1 = qd1; l0 = ql0; l1 = ql1; turn = start;
    exp_d.delete(); exp_s.delete();
    while (c0.size() + c1.size() > 0) begin
      if (turn == 0 && c0.size() == 0) turn = 1;
      if (turn == 1 && c1.size() == 0) turn = 0;
      last = 1'b0;
      while (!last) begin
        if (turn == 0) begin
          if (c0.size() == 0) break;
          exp_d.push_back(c0.pop_front()); exp_s.push_back(0); last = l0.pop_front();
        end else begin
          if (c1.size() == 0) break;
          exp_d.push_back(c1.pop_front()); exp_s.push_back(1); last = l1.pop_front();
        end
      end
      turn = 1 - turn;
    end
  endfunction

  task automatic check_stream(input string tag);
    int n;
    check($sformatf("%s_count", tag), 32'(cap_d.size()), 32'(exp_d.size()));
    n = (cap_d.size() < exp_d.size()) ? cap_d.size() : exp_d.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_data%0d", tag, i), 32'(cap_d[i]), 32'(exp_d[i]));
      check($sformatf("%s_src%0d", tag, i), 32'(cap_s[i]), 32'(exp_s[i]));
    end
    cap_d.delete(); cap_s.delete(); exp_d.delete(); exp_s.delete();
  endtask

  initial begin
    bit f_ready, f_start, f_to;
    int nt0, nmsg, len;
    tests = 0; fails = 0; cyc = 0; n_timeout = 0; bad_start = 0;
    t_start = 0; t_timeout = 0; prev_ready = 1'b1;
    rst = 1'b1; bp_hold = 1'b0; req_valid = '0; req_data = '0; req_last = '0;

    // Reset values
    do_reset();
    step();
    check("rst_grant", 32'(s_grant), 0);
    check("rst_txdata", 32'(s_data), 0);
    check("rst_txstart", 32'(s_start), 0);
    check("rst_ready", 32'(s_ready), 0);
    check("rst_timeout", 32'(s_timeout), 0);
    check("rst_busy", 32'(s_busy), 0);

    // 1: single byte latency
    push(0, 8'h41, 1'b1);
    build_exp(0);
    step(); check("t1_ready_t0", 32'(s_ready), 0);
    step(); check("t1_ready_t1", 32'(s_ready), 32'h1);
    check("t1_grant_t1", 32'(s_grant), 32'h1);
    check("t1_busy_t1", 32'(s_busy), 1);
    step(); check("t1_start_t2", 32'(s_start), 1);
    check("t1_data_t2", 32'(s_data), 32'h41);
    check("t1_ready_t2", 32'(s_ready), 0);
    wait_idle("t1");
    check("t1_grant_released", 32'(grant), 0);
    check_stream("t1");

    // 2: contention from reset
    do_reset();
    push(0, 8'h10, 1'b1); push(0, 8'h11, 1'b1);
    push(1, 8'h20, 1'b1); push(1, 8'h21, 1'b1);
    build_exp(0);
    wait_idle("t2");
    check_stream("t2");

    // 3: message lock
    do_reset();
    push(0, 8'h41, 1'b0); push(0, 8'h42, 1'b0); push(0, 8'h43, 1'b1);
    push(1, 8'h5A, 1'b1);
    build_exp(0);
    wait_idle("t3");
    check_stream("t3");

    // 4a: timeout with req1 waiting
    do_reset();
    nt0 = n_timeout;
    push(0, 8'h01, 1'b0); push(1, 8'h02, 1'b1);
    wait_idle("t4a");
    check("t4a_timeouts", 32'(n_timeout - nt0), 1);
    check("t4a_timing", 32'(t_timeout - t_start), 32'(BUSY_CYC + 2 + int'(LT)));
    exp_d = '{8'h01, 8'h02}; exp_s = '{0, 1};
    check_stream("t4a");

    // 4b: after a timeout of req0 the pointer favours req1 on a tie
    nt0 = n_timeout;
    push(0, 8'h04, 1'b0);
    for (int i = 0; i < 200 && n_timeout == nt0; i++) step();
    wait_idle("t4b_to");
    check("t4b_timeouts", 32'(n_timeout - nt0), 1);
    push(0, 8'h05, 1'b1); push(1, 8'h06, 1'b1);
    wait_idle("t4b");
    exp_d = '{8'h04, 8'h06, 8'h05}; exp_s = '{0, 1, 0};
    check_stream("t4b");

    // 5: backpressure in ISSUE
    nt0 = n_timeout;
    bp_hold = 1'b1;
    push(0, 8'h55, 1'b1);
    f_ready = 0; f_start = 0; f_to = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      f_ready |= (s_ready != 0); f_start |= s_start; f_to |= s_timeout;
    end
    check("t5_busy_held", 32'(s_busy), 1);
    check("t5_no_ready", 32'(f_ready), 0);
    check("t5_no_start", 32'(f_start), 0);
    check("t5_no_timeout", 32'(f_to), 0);
    bp_hold = 1'b0;
    wait_idle("t5");
    check("t5_timeouts", 32'(n_timeout - nt0), 0);
    exp_d = '{8'h55}; exp_s = '{0};
    check_stream("t5");

    // 6: reset while waiting on the serialiser
    push(0, 8'h66, 1'b1);
    for (int i = 0; i < 20 && cap_d.size() == 0; i++) step();
    check("t6_started", 32'(cap_d.size()), 1);
    step(); step();
    rst = 1'b1; step(); rst = 1'b0;
    step();
    check("t6_rst_grant", 32'(s_grant), 0);
    check("t6_rst_txdata", 32'(s_data), 0);
    check("t6_rst_txstart", 32'(s_start), 0);
    check("t6_rst_ready", 32'(s_ready), 0);
    check("t6_rst_timeout", 32'(s_timeout), 0);
    check("t6_rst_busy", 32'(s_busy), 0);
    check("t6_uart_still_busy", 32'(tx_ready), 0);
    cap_d.delete(); cap_s.delete();
    push(1, 8'h77, 1'b1);
    wait_idle("t6");
    exp_d = '{8'h77}; exp_s = '{1};
    check_stream("t6");

    // Randomized backlogged traffic against the alternation model
    for (int round = 0; round < 4; round++) begin
      do_reset();
      for (int r = 0; r < 2; r++) begin
        nmsg = (r == 0) ? int'($urandom_range(1, 4)) : int'($urandom_range(0, 3));
        for (int m = 0; m < nmsg; m++) begin
          len = int'($urandom_range(1, 3));
          for (int b = 0; b < len; b++) push(r, 8'($urandom), (b == len - 1));
        end
      end
      build_exp(0);
      wait_idle($sformatf("rnd%0d", round));
      check_stream($sformatf("rnd%0d", round));
    end

    check("start_only_after_ready", 32'(bad_start), 0);
    check("total_timeouts", 32'(n_timeout), 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
